// File: rtl/usb_tx_fifo_if.sv
// Byte-stream handshake between the AHB push side, the usb_tx pop side and the TX FIFO.
interface usb_tx_fifo_if;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_tx_packet_data;
    logic       clear;
    logic [7:0] tx_packet_data;
    logic [6:0] tx_packet_size;
    logic       buffer_full;
    logic       buffer_empty;
    logic       overflow_err;
    logic       underflow_err;

    // FIFO side
    modport slave (
        input  store_tx_data, tx_data, get_tx_packet_data, clear,
        output tx_packet_data, tx_packet_size, buffer_full, buffer_empty,
               overflow_err, underflow_err
    );

    // Producer/consumer side
    modport master (
        output store_tx_data, tx_data, get_tx_packet_data, clear,
        input  tx_packet_data, tx_packet_size, buffer_full, buffer_empty,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/usb_tx_fifo.sv
// Transmit FIFO feeding usb_tx: FWFT head byte, occupancy count, sticky error flags.
module usb_tx_fifo #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic           clk,
    input  logic           n_rst,
    usb_tx_fifo_if.slave   bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow_err;
    logic              r_underflow_err;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;

    // A push into a full buffer is still accepted when the same cycle frees a slot
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop_acc  = bus.get_tx_packet_data & ~w_empty;
    assign w_push_acc = bus.store_tx_data & (~w_full | w_pop_acc);

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(w_push_acc);
            r_rd_ptr <= r_rd_ptr + ADDR_W'(w_pop_acc);
            r_count  <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop_acc);
            if (bus.store_tx_data && w_full && !w_pop_acc) begin
                r_overflow_err <= 1'b1;
            end
            if (bus.get_tx_packet_data && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally unreset; empty-gating hides stale bytes
    always_ff @(posedge clk) begin
        if (!bus.clear && w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.tx_data;
        end
    end

    assign bus.tx_packet_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign bus.tx_packet_size = r_count;
    assign bus.buffer_full    = w_full;
    assign bus.buffer_empty   = w_empty;
    assign bus.overflow_err   = r_overflow_err;
    assign bus.underflow_err  = r_underflow_err;
endmodule
